// File: rtl/bcd_cnt_pkg.sv
// Shared types and constants for the cascaded BCD down-counter.
package bcd_cnt_pkg;

   localparam int unsigned     BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic digit_ok(input logic [BCD_W-1:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down-counter: load, decrement with 0->9 wrap, borrow out.
module bcd_down_digit
   import bcd_cnt_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [BCD_W-1:0] ld_val,
   input  logic             dec_in,
   output logic [BCD_W-1:0] q,
   output logic             borrow_out
);

   logic [BCD_W-1:0] r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= ld_val;
      end else if (dec_in) begin
         r_q <= (r_q == '0) ? BCD_MAX : (r_q - 4'd1);
      end
   end

   assign q          = r_q;
   assign borrow_out = dec_in & (r_q == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with terminal-count pulse, auto-reload and
// load validation. Digits are chained by borrow; the FSM lives here.
module bcd_down_counter
   import bcd_cnt_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  auto_reload,
   output logic [4*DIGITS-1:0]   count,
   output logic                  zero,
   output logic                  tc_pulse,
   output logic                  busy,
   output logic                  load_err
);

   localparam int unsigned W = BCD_W * DIGITS;

   state_t         r_state;
   state_t         w_next;
   logic [W-1:0]   r_reload;
   logic           r_load_err;
   logic [W-1:0]   w_count;
   logic [W-1:0]   w_digit_ld_val;
   logic           w_load_ok;
   logic           w_reload_go;
   logic           w_digit_ld;
   logic [DIGITS:0] w_dec;

   always_comb begin
      w_load_ok = load;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!digit_ok(load_val[i*BCD_W +: BCD_W])) w_load_ok = 1'b0;
      end
   end

   // Any load request, valid or not, suppresses counting and DONE handling.
   assign w_reload_go    = ~load & (r_state == DONE) & auto_reload & (r_reload != '0);
   assign w_digit_ld     = w_load_ok | w_reload_go;
   assign w_digit_ld_val = w_load_ok ? load_val : r_reload;
   assign w_dec[0]       = (r_state == RUN) & en & ~load;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_down_digit u_digit (
         .clk        (clk),
         .rst        (rst),
         .ld         (w_digit_ld),
         .ld_val     (w_digit_ld_val[g*BCD_W +: BCD_W]),
         .dec_in     (w_dec[g]),
         .q          (w_count[g*BCD_W +: BCD_W]),
         .borrow_out (w_dec[g+1])
      );
   end

   // The FSM leaves RUN at zero, so the top digit can never borrow.
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !w_dec[DIGITS]);

   always_comb begin
      w_next = r_state;
      if (load) begin
         if (w_load_ok) w_next = (load_val != '0) ? RUN : IDLE;
      end else begin
         unique case (r_state)
            IDLE: w_next = IDLE;
            RUN:  if (en && (w_count == W'(1))) w_next = DONE;
            DONE: w_next = w_reload_go ? RUN : IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_reload   <= '0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_load_err <= load & ~w_load_ok;
         if (w_load_ok) r_reload <= load_val;
      end
   end

   assign count    = w_count;
   assign zero     = (w_count == '0);
   assign tc_pulse = (r_state == DONE);
   assign busy     = (r_state == RUN);
   assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Randomized + directed bench for bcd_down_counter against an integer-valued timer model.
module tb_bcd_down_counter;

   localparam int DIG = 2;
   localparam int W   = 4 * DIG;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         en;
   logic         auto_reload;
   logic [W-1:0] count;
   logic         zero;
   logic         tc_pulse;
   logic         busy;
   logic         load_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: decimal value, reload value, phase (0 idle, 1 counting, 2 terminal), error flag
   int m_val, m_rel, m_ph;
   bit m_err;

   bcd_down_counter #(.DIGITS(DIG)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .en          (en),
      .auto_reload (auto_reload),
      .count       (count),
      .zero        (zero),
      .tc_pulse    (tc_pulse),
      .busy        (busy),
      .load_err    (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < DIG; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_valid(input logic [W-1:0] v, output int dec);
      int mul = 1;
      dec = 0;
      for (int i = 0; i < DIG; i++) begin
         if (v[i*4 +: 4] > 4'd9) return 1'b0;
         dec += int'(v[i*4 +: 4]) * mul;
         mul *= 10;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_val = 0; m_rel = 0; m_ph = 0; m_err = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".count"}, 32'(count), 32'(to_bcd(m_val)));
      check({tag, ".zero"},  32'(zero),  32'(m_val == 0));
      check({tag, ".tc"},    32'(tc_pulse), 32'(m_ph == 2));
      check({tag, ".busy"},  32'(busy),  32'(m_ph == 1));
      check({tag, ".lderr"}, 32'(load_err), 32'(m_err));
   endtask

   task automatic step(input string tag, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic ar);
      int dec;
      load = ld; load_val = lv; en = e; auto_reload = ar;
      @(posedge clk);
      m_err = 1'b0;
      if (ld) begin
         if (bcd_valid(lv, dec)) begin
            m_val = dec; m_rel = dec;
            m_ph  = (dec != 0) ? 1 : 0;
         end else begin
            m_err = 1'b1;
         end
      end else if (m_ph == 1) begin
         if (e) begin
            m_val = m_val - 1;
            if (m_val == 0) m_ph = 2;
         end
      end else if (m_ph == 2) begin
         if (ar && m_rel != 0) begin
            m_val = m_rel; m_ph = 1;
         end else begin
            m_ph = 0;
         end
      end
      #1;
      check_all(tag);
   endtask

   task automatic async_reset_check(input string tag);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1 check_all({tag, ".held"});
      #2 rst = 1'b1;
   endtask

   initial begin
      logic [W-1:0] lv;
      rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
      model_reset();
      #3 check_all("reset");
      #9 rst = 1'b1;

      // 25 down to 0 with a borrow at 20->19, then terminal pulse and idle
      step("ld25", 1'b1, 8'h25, 1'b0, 1'b0);
      for (int i = 0; i < 28; i++) step("cnt25", 1'b0, '0, 1'b1, 1'b0);

      // auto-reload every 4 cycles
      step("ld03", 1'b1, 8'h03, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) step("auto03", 1'b0, '0, 1'b1, 1'b1);

      // invalid load while running at 07
      step("ld09", 1'b1, 8'h09, 1'b0, 1'b0);
      step("dec", 1'b0, '0, 1'b1, 1'b0);
      step("dec", 1'b0, '0, 1'b1, 1'b0);
      step("bad3A", 1'b1, 8'h3A, 1'b1, 1'b0);
      step("afterbad", 1'b0, '0, 1'b0, 1'b0);

      // enable gating, mid-run load, load on terminal edge
      step("ld12", 1'b1, 8'h12, 1'b0, 1'b0);
      step("en1", 1'b0, '0, 1'b1, 1'b0);
      step("en0", 1'b0, '0, 1'b0, 1'b0);
      step("en0", 1'b0, '0, 1'b0, 1'b0);
      step("en1", 1'b0, '0, 1'b1, 1'b0);
      step("ld40", 1'b1, 8'h40, 1'b1, 1'b0);
      step("ld01", 1'b1, 8'h01, 1'b0, 1'b0);
      step("ldtc", 1'b1, 8'h40, 1'b1, 1'b0);
      step("posttc", 1'b0, '0, 1'b0, 1'b0);
      step("ld00", 1'b1, 8'h00, 1'b1, 1'b1);
      step("idle", 1'b0, '0, 1'b1, 1'b1);

      // asynchronous reset mid-run at 14
      step("ld14", 1'b1, 8'h14, 1'b0, 1'b0);
      async_reset_check("areset");
      for (int i = 0; i < 3; i++) step("postrst", 1'b0, '0, 1'b1, 1'b1);

      // randomized traffic, biased toward small loads so terminal counts occur
      for (int i = 0; i < 3000; i++) begin
         lv = W'($urandom);
         if ($urandom_range(0, 3) != 0) lv = to_bcd($urandom_range(0, 6));
         step("rand", ($urandom_range(0, 15) == 0), lv,
              ($urandom_range(0, 3) != 0), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
